// File: rtl/regfile_sb.sv
// Parametrised multi-port register file with an integrated busy scoreboard.
// Reads are combinational (optionally bypassing same-cycle writes); writes,
// busy bits and the registered busy population count update on the rising
// edge of clk. Register 0 can be hard-wired to zero.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*AW-1:0]   wr_addr,
    input  logic [NUM_WR*XLEN-1:0] wr_data,
    input  logic                   sb_set_en,
    input  logic [AW-1:0]          sb_set_addr,
    output logic [AW:0]            busy_count
);

    logic [XLEN-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [AW:0]      cnt_nxt;
    logic [NUM_WR-1:0] wr_ok;
    logic             set_ok;

    // Qualify write ports and the scoreboard set against the hard-wired zero register.
    always_comb begin
        wr_ok = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_ok[w] = wr_en[w];
            if (ZERO_REG != 0 && wr_addr[w*AW +: AW] == '0)
                wr_ok[w] = 1'b0;
        end
        set_ok = sb_set_en && !(ZERO_REG != 0 && sb_set_addr == '0);
    end

    // Next busy vector: writebacks clear, then issue sets so a same-cycle set wins.
    always_comb begin
        busy_nxt = busy;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_ok[w])
                busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
        end
        if (set_ok)
            busy_nxt[sb_set_addr] = 1'b1;
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end

    // Scoreboard state and its registered population count.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_count <= cnt_nxt;
        end
    end

    // Register storage; later (higher-index) ports override earlier ones on a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ok[w])
                    mem[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            b;

        assign a = rd_addr[k*AW +: AW];

        // Read mux with optional forwarding of same-cycle writes (highest port wins).
        always_comb begin
            d = mem[a];
            b = busy[a];
            if (BYPASS != 0) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_ok[w] && wr_addr[w*AW +: AW] == a) begin
                        d = wr_data[w*XLEN +: XLEN];
                        b = 1'b0;
                    end
                end
            end
            if (ZERO_REG != 0 && a == '0) begin
                d = '0;
                b = 1'b0;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = d;
        assign rd_busy[k]              = b;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one default instance (1 write port, bypass, zero reg)
// and one with 2 write ports, no bypass and an ordinary register 0, both
// compared each cycle against an array-based reference model.
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [9:0]  rd_addr;
    logic        we0, we1;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        sb_set_en;
    logic [4:0]  sb_set_addr;

    logic [63:0] rda, rdb;
    logic [1:0]  rba, rbb;
    logic [5:0]  cnta, cntb;

    int total = 0;
    int bad   = 0;
    bit mvalid = 0;

    logic [31:0] m_reg  [2][32];
    bit          m_busy [2][32];

    regfile_sb dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rda), .rd_busy(rba),
        .wr_en(we0), .wr_addr(wa0), .wr_data(wd0),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .busy_count(cnta)
    );

    regfile_sb #(.NUM_WR(2), .BYPASS(0), .ZERO_REG(0)) dut2 (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rdb), .rd_busy(rbb),
        .wr_en({we1, we0}), .wr_addr({wa1, wa0}), .wr_data({wd1, wd0}),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .busy_count(cntb)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int m_count(input int d);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[d][i]);
        return c;
    endfunction

    // Compare reads (with current inputs) and busy_count against the model.
    task automatic check_now();
        for (int d = 0; d < 2; d++) begin
            bit zr  = (d == 0);
            bit byp = (d == 0);
            if (!rst) begin
                for (int k = 0; k < 2; k++) begin
                    logic [4:0]  a;
                    logic [31:0] ed, gd;
                    bit          eb;
                    logic        gb;
                    a  = rd_addr[k*5 +: 5];
                    ed = m_reg[d][a];
                    eb = m_busy[d][a];
                    if (byp && we0 && wa0 == a) begin ed = wd0; eb = 0; end
                    if (byp && d == 1 && we1 && wa1 == a) begin ed = wd1; eb = 0; end
                    if (zr && a == 5'd0) begin ed = '0; eb = 0; end
                    gd = (d == 0) ? rda[k*32 +: 32] : rdb[k*32 +: 32];
                    gb = (d == 0) ? rba[k] : rbb[k];
                    chk($sformatf("rd_data_i%0d_p%0d_a%0d", d, k, a), {32'd0, gd}, {32'd0, ed});
                    chk($sformatf("rd_busy_i%0d_p%0d_a%0d", d, k, a), {63'd0, gb}, {63'd0, eb});
                end
            end
            chk($sformatf("busy_count_i%0d", d), {58'd0, (d == 0) ? cnta : cntb}, 64'(m_count(d)));
        end
    endtask

    // Apply the rules of one clock edge to the model.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit zr = (d == 0);
            if (rst) begin
                for (int i = 0; i < 32; i++) begin
                    m_reg[d][i]  = '0;
                    m_busy[d][i] = 0;
                end
            end else begin
                if (we0 && !(zr && wa0 == 5'd0)) begin m_reg[d][wa0] = wd0; m_busy[d][wa0] = 0; end
                if (d == 1 && we1) begin m_reg[d][wa1] = wd1; m_busy[d][wa1] = 0; end
                if (sb_set_en && !(zr && sb_set_addr == 5'd0)) m_busy[d][sb_set_addr] = 1;
            end
        end
        if (rst) mvalid = 1;
    endtask

    task automatic cycle();
        @(negedge clk);
        #1;
        if (mvalid) check_now();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 0; we0 = 0; we1 = 0; sb_set_en = 0;
    endtask

    initial begin
        rst = 1; we0 = 0; we1 = 0; sb_set_en = 0;
        wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; sb_set_addr = 0; rd_addr = 0;
        cycle();
        idle();

        // Reset clears data and pending producers
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; sb_set_en = 1; sb_set_addr = 7; cycle();
        idle(); cycle();
        rst = 1; cycle();
        idle(); rd_addr = {5'd7, 5'd5}; #2;
        chk("rst_rd5", {32'd0, rda[31:0]}, 64'd0);
        chk("rst_rd7", {32'd0, rda[63:32]}, 64'd0);
        chk("rst_busy", {62'd0, rba}, 64'd0);
        chk("rst_cnt", {58'd0, cnta}, 64'd0);
        cycle();

        // Register 0: hard-wired on dut, ordinary on dut2
        we0 = 1; wa0 = 0; wd0 = 32'h1234; cycle();
        idle(); rd_addr = 0; #2;
        chk("zero_rd", {32'd0, rda[31:0]}, 64'd0);
        chk("r0_ordinary", {32'd0, rdb[31:0]}, 64'h1234);
        cycle();

        // Basic write then read on both ports
        we0 = 1; wa0 = 3; wd0 = 32'hA5A5A5A5; cycle();
        idle(); rd_addr = {5'd3, 5'd3}; #2;
        chk("rw3_p0", {32'd0, rda[31:0]}, 64'hA5A5A5A5);
        chk("rw3_p1", {32'd0, rda[63:32]}, 64'hA5A5A5A5);
        cycle();
        we0 = 1; wa0 = 31; wd0 = 32'hFFFFFFFF; cycle();
        idle(); rd_addr = {5'd31, 5'd31}; #2;
        chk("rw31", {32'd0, rda[31:0]}, 64'hFFFFFFFF);
        cycle();

        // Bypass versus stored-state reads
        we0 = 1; wa0 = 9; wd0 = 32'h11; rd_addr = {5'd9, 5'd9}; #2;
        chk("byp_on", {32'd0, rda[31:0]}, 64'h11);
        chk("byp_off_old", {32'd0, rdb[31:0]}, 64'h0);
        cycle();
        idle(); #2;
        chk("byp_off_next", {32'd0, rdb[31:0]}, 64'h11);
        cycle();

        // Scoreboard set visible next cycle, cleared by bypassed writeback
        sb_set_en = 1; sb_set_addr = 4; rd_addr = {5'd4, 5'd4}; #2;
        chk("sb_same_cycle", {63'd0, rba[0]}, 64'd0);
        cycle();
        idle(); #2;
        chk("sb_next", {63'd0, rba[0]}, 64'd1);
        chk("sb_cnt", {58'd0, cnta}, 64'd1);
        cycle();
        cycle();
        we0 = 1; wa0 = 4; wd0 = 32'h77; #2;
        chk("wb_busy", {63'd0, rba[0]}, 64'd0);
        chk("wb_data", {32'd0, rda[31:0]}, 64'h77);
        cycle();
        idle(); #2;
        chk("wb_cnt", {58'd0, cnta}, 64'd0);
        cycle();

        // Set and clear of the same register: set wins, data still updates
        sb_set_en = 1; sb_set_addr = 6; we0 = 1; wa0 = 6; wd0 = 32'h55; cycle();
        idle(); rd_addr = {5'd6, 5'd6}; #2;
        chk("sim_data", {32'd0, rda[31:0]}, 64'h55);
        chk("sim_busy", {63'd0, rba[0]}, 64'd1);
        chk("sim_cnt", {58'd0, cnta}, 64'd1);
        cycle();

        // Two write ports to one register: higher port wins
        we0 = 1; wa0 = 2; wd0 = 32'h1; we1 = 1; wa1 = 2; wd1 = 32'h2; cycle();
        idle(); rd_addr = {5'd2, 5'd2}; #2;
        chk("wr2_win", {32'd0, rdb[31:0]}, 64'h2);
        cycle();

        // Fill the scoreboard, then hold the count with set+clear per cycle
        for (int i = 1; i < 32; i++) begin
            sb_set_en = 1; sb_set_addr = 5'(i); cycle();
        end
        idle(); #2;
        chk("sat_cnt", {58'd0, cnta}, 64'd31);
        cycle();
        we0 = 1; wa0 = 1; wd0 = 32'h100; cycle();
        for (int i = 2; i < 32; i++) begin
            we0 = 1; wa0 = 5'(i); wd0 = 32'(i); sb_set_en = 1; sb_set_addr = 5'(i - 1);
            cycle();
        end
        idle(); #2;
        chk("hold_cnt", {58'd0, cnta}, 64'd30);
        cycle();

        // Randomised traffic with occasional reset and clustered addresses
        for (int n = 0; n < 3000; n++) begin
            bit narrow;
            narrow      = 1'($urandom_range(0, 1));
            rst         = ($urandom_range(0, 63) == 0);
            we0         = 1'($urandom_range(0, 1));
            we1         = 1'($urandom_range(0, 1));
            wa0         = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            wa1         = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            wd0         = $urandom;
            wd1         = $urandom;
            sb_set_en   = 1'($urandom_range(0, 1));
            sb_set_addr = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            rd_addr     = narrow ? {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))}
                                 : 10'($urandom_range(0, 1023));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised multi-port register file for the CPU datapath, successor to the fixed 32x32 2R1W file. It adds configurable width, depth, read-port and write-port count, optional write-to-read bypass, and an optional hard-wired zero register. It also carries an integrated per-register busy scoreboard, set at issue and cleared at writeback, so later multi-cycle/pipelined cores can detect RAW hazards.

Parameters:
XLEN, 32, data width of each register in bits
DEPTH, 32, number of registers (power of 2, >= 2)
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 1, number of write ports (1..2)
BYPASS, 1, 1 = same-cycle write data and busy-clear are forwarded to reads; 0 = reads see stored state only
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy
AW, $clog2(DEPTH), derived address width (localparam, not overridable)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
rd_addr  in  NUM_RD*AW  read addresses; port k at bits [k*AW +: AW]
rd_data  out  NUM_RD*XLEN  read data; port k at bits [k*XLEN +: XLEN]
rd_busy  out  NUM_RD  1 = register on port k has a pending producer
wr_en  in  NUM_WR  write enable per write port
wr_addr  in  NUM_WR*AW  write addresses
wr_data  in  NUM_WR*XLEN  write data
sb_set_en  in  1  mark sb_set_addr busy (instruction issue)
sb_set_addr  in  AW  destination register being issued
busy_count  out  AW+1  number of registers currently busy (registered)

Behaviour:
- Single clock domain. Reset is synchronous and active-high: on a rising edge with rst=1, all registers clear to 0, all busy bits clear to 0, and busy_count goes to 0. All wr_en and sb_set_en in that cycle are ignored. The same holds for reset asserted mid-operation; nothing pending survives it.
- Write: on an edge with wr_en[i]=1 and rst=0, reg[wr_addr[i]] <= wr_data[i] and busy[wr_addr[i]] <= 0.
- Two write ports to the same address in one cycle: the higher port index wins for both data and busy-clear.
- Scoreboard set: on an edge with sb_set_en=1, busy[sb_set_addr] <= 1.
- Set and clear of the same address in one cycle: set wins (a new producer is issued as the old one retires), so the busy bit ends at 1 while the data still updates.
- ZERO_REG=1: address 0 writes are dropped, sb_set to address 0 is dropped, rd_data=0 and rd_busy=0 for address 0. ZERO_REG=0: register 0 is an ordinary register.
- Reads are combinational, with zero latency from rd_addr.
  - BYPASS=1: if any write port hits rd_addr[k] this cycle, rd_data[k] = that wr_data (highest index wins) and rd_busy[k] = 0.
  - Otherwise (and always when BYPASS=0): rd_data[k] = reg[rd_addr[k]] and rd_busy[k] = busy[rd_addr[k]].
- sb_set_en never affects reads in the same cycle; the new busy bit is visible from the next cycle.
- busy_count is registered. It equals the popcount of the busy vector after the edge and is updated every cycle with the net effect of sets and clears. Range is 0..DEPTH; with ZERO_REG=1 the maximum is DEPTH-1.
- Clearing an already-clear busy bit, or setting an already-set one, is legal and has no effect on count.
- Out-of-range addresses cannot occur because DEPTH is a power of 2.
- No X propagation: every register and busy bit has a defined reset value.

Test Plan:
- Reset/zero: assert rst 2 cycles after writing reg5=0xDEADBEEF and setting busy[7]. After reset, reading 5 and 7 gives rd_data=0, rd_busy=0, busy_count=0. With ZERO_REG=1, a write of 0x1234 to address 0 then a read of 0 gives 0.
- Basic R/W: write reg3=0xA5A5A5A5, then next cycle read 3 on both ports: both rd_data=0xA5A5A5A5. Write reg31=0xFFFFFFFF, then read 31 gives 0xFFFFFFFF.
- Bypass: with BYPASS=1, write reg9=0x11 and read 9 in the same cycle: rd_data=0x11 in that cycle. With BYPASS=0, the same stimulus gives the old value 0 in that cycle and 0x11 on the next.
- Scoreboard: sb_set 4 at cycle t, so rd_busy(4)=0 at t, 1 at t+1, and busy_count=1. At t+3, write 4=0x77 with BYPASS=1: rd_busy=0 and rd_data=0x77 in the same cycle, busy_count=0 next cycle.
- Simultaneous: in one cycle, sb_set 6 while writing 6=0x55: next cycle reg6=0x55, busy[6]=1, busy_count increments by 1. With NUM_WR=2, both ports write reg2 (0x1, 0x2): reg2=0x2.
- Count saturation: set all addresses 1..31 over 31 cycles: busy_count=31 (ZERO_REG=1). Then one sb_set plus one write per cycle to different addresses holds the count constant.
